// File: rtl/prbs_bit_checker.sv
// Receive-side PRBS checker. A local Fibonacci LFSR is seeded directly
// from the incoming bits and then free-runs. Each bit that matches the
// prediction is counted in number and each mismatch in err_count. Too many
// errors inside one monitor window make the checker drop back and reseed.
module prbs_bit_checker #(
    parameter int PRBS_ORDER = 7,
    parameter int PRBS_TAP   = 6,
    parameter int LOCK_CNT   = 16,
    parameter int WINDOW     = 64,
    parameter int UNLOCK_ERR = 8,
    parameter int CNT_W      = 32
) (
    input  logic             emu_clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic [CNT_W-1:0] number,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int SEED_W  = $clog2(PRBS_ORDER + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

    typedef enum logic [1:0] {
        SEED = 2'd0,
        LOCK = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PRBS_ORDER-1:0] lfsr_q, lfsr_d;
    logic [SEED_W-1:0]     seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]     win_err_q, win_err_d;
    logic [CNT_W-1:0]      number_q, number_d;
    logic [CNT_W-1:0]      err_q, err_d;
    logic                  locked_q, locked_d;

    logic                  pred;
    logic                  hit;
    logic [WERR_W-1:0]     win_err_inc;

    // Prediction of the next received bit and whether the current bit agrees.
    assign pred        = lfsr_q[PRBS_ORDER-1] ^ lfsr_q[PRBS_TAP-1];
    assign hit         = (in_bit == pred);
    assign win_err_inc = win_err_q + (hit ? WERR_W'(0) : WERR_W'(1));

    // Next-state logic: synchronisation state machine, LFSR and counters.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        number_d    = number_q;
        err_d       = err_q;

        if (in_valid) begin
            case (state_q)
                SEED: begin
                    // Load the received bit itself so the LFSR converges on the stream.
                    lfsr_d     = {lfsr_q[PRBS_ORDER-2:0], in_bit};
                    seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    if (seed_cnt_q == SEED_W'(PRBS_ORDER - 1)) begin
                        state_d     = LOCK;
                        match_cnt_d = '0;
                    end
                end
                LOCK: begin
                    // Free-running from here on, so a bad bit never enters the LFSR.
                    lfsr_d = {lfsr_q[PRBS_ORDER-2:0], pred};
                    if (hit) begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                        if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d   = RUN;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end
                end
                RUN: begin
                    lfsr_d = {lfsr_q[PRBS_ORDER-2:0], pred};
                    if (hit) begin
                        if (number_q != {CNT_W{1'b1}}) number_d = number_q + CNT_W'(1);
                    end else begin
                        if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
                    end
                    win_err_d = win_err_inc;
                    if (win_err_inc == WERR_W'(UNLOCK_ERR)) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                end
                default: begin
                    state_d    = SEED;
                    seed_cnt_d = '0;
                end
            endcase
        end

        // Clear takes precedence over counting a coincident bit.
        if (clear) begin
            number_d = '0;
            err_d    = '0;
        end

        locked_d = (state_d == RUN);
    end

    // State register with synchronous reset.
    always_ff @(posedge emu_clk) begin
        if (rst) begin
            state_q     <= SEED;
            lfsr_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            number_q    <= '0;
            err_q       <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            number_q    <= number_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign number    = number_q;
    assign err_count = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_prbs_bit_checker.sv
// Bench for prbs_bit_checker: a 32-bit and an 8-bit counter build share one
// stimulus. Directed table, hand sequences, then randomized traffic checked
// against a bit-history reference model.
module tb_prbs_bit_checker;

    localparam int ORDER = 7;
    localparam int TAP   = 6;
    localparam int LOCKN = 16;
    localparam int WIN   = 64;
    localparam int UNL   = 8;

    logic        emu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        locked_w, locked_n;
    logic [31:0] number_w, err_w;
    logic [7:0]  number_n, err_n;
    logic [1:0]  state_w, state_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 emu_clk = ~emu_clk;

    prbs_bit_checker #(.PRBS_ORDER(ORDER), .PRBS_TAP(TAP), .LOCK_CNT(LOCKN),
                       .WINDOW(WIN), .UNLOCK_ERR(UNL), .CNT_W(32)) u_dut_w (
        .emu_clk(emu_clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_bit(in_bit), .locked(locked_w), .number(number_w),
        .err_count(err_w), .state(state_w));

    prbs_bit_checker #(.PRBS_ORDER(ORDER), .PRBS_TAP(TAP), .LOCK_CNT(LOCKN),
                       .WINDOW(WIN), .UNLOCK_ERR(UNL), .CNT_W(8)) u_dut_n (
        .emu_clk(emu_clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_bit(in_bit), .locked(locked_n), .number(number_n),
        .err_count(err_n), .state(state_n));

    // Transmitter: bit history obeying t[n] = t[n-ORDER] ^ t[n-TAP].
    bit tx_q[$];

    function automatic bit gen_bit();
        bit b;
        b = tx_q[tx_q.size()-ORDER] ^ tx_q[tx_q.size()-TAP];
        tx_q.push_back(b);
        void'(tx_q.pop_front());
        return b;
    endfunction

    // Reference model: mode 0/1/2, history of bits the checker has adopted.
    int     m_mode, m_seed, m_match, m_wpos, m_werr;
    longint m_num, m_err;
    bit     m_hist[$];

    function automatic void model_reset();
        m_mode = 0; m_seed = 0; m_match = 0; m_wpos = 0; m_werr = 0;
        m_num = 0; m_err = 0;
        m_hist.delete();
        for (int i = 0; i < ORDER; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit c, input bit r);
        bit p;
        if (r) begin
            model_reset();
            return;
        end
        if (v) begin
            p = m_hist[m_hist.size()-ORDER] ^ m_hist[m_hist.size()-TAP];
            if (m_mode == 0) begin
                m_hist.push_back(b);
                m_seed++;
                if (m_seed == ORDER) begin m_mode = 1; m_match = 0; end
            end else if (m_mode == 1) begin
                m_hist.push_back(p);
                if (b == p) begin
                    m_match++;
                    if (m_match == LOCKN) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
                end else begin
                    m_mode = 0; m_seed = 0;
                end
            end else begin
                m_hist.push_back(p);
                if (!c) begin
                    if (b == p) m_num++; else m_err++;
                end
                if (b != p) m_werr++;
                m_wpos++;
                if (m_werr >= UNL) begin
                    m_mode = 0; m_seed = 0;
                end else if (m_wpos == WIN) begin
                    m_wpos = 0; m_werr = 0;
                end
            end
            void'(m_hist.pop_front());
        end
        if (c) begin m_num = 0; m_err = 0; end
    endfunction

    function automatic longint clampv(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input int st, input bit lk,
                             input longint num, input longint err);
        chk({tag, " state32"}, longint'(state_w), longint'(st));
        chk({tag, " locked32"}, longint'(locked_w), longint'(lk));
        chk({tag, " number32"}, longint'(number_w), clampv(num, 64'd4294967295));
        chk({tag, " err32"}, longint'(err_w), clampv(err, 64'd4294967295));
        chk({tag, " state8"}, longint'(state_n), longint'(st));
        chk({tag, " number8"}, longint'(number_n), clampv(num, 255));
        chk({tag, " err8"}, longint'(err_n), clampv(err, 255));
    endtask

    // One clock: apply inputs, advance the model at the edge, settle.
    task automatic drive(input bit v, input bit b, input bit c, input bit r);
        in_valid = v; in_bit = b; clear = c; rst = r;
        @(posedge emu_clk);
        model_step(v, b, c, r);
        #1;
    endtask

    task automatic clean_bits(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, gen_bit(), 1'b0, 1'b0);
    endtask

    typedef struct {
        bit     rst_c;
        int     n;
        bit     flip;
        bit     clr;
        int     st;
        bit     lk;
        longint num;
        longint err;
    } rec_t;

    rec_t tbl[$];

    initial begin
        bit v, b, c, r, f;
        int burst;

        for (int i = 0; i < ORDER; i++) tx_q.push_back(1'b1);
        model_reset();

        // Directed table: {rst, bits, flip, clear, state, locked, number, err}.
        tbl.push_back('{1'b0,   7, 1'b0, 1'b0, 1, 1'b0,   0, 0});
        tbl.push_back('{1'b0,  15, 1'b0, 1'b0, 1, 1'b0,   0, 0});
        tbl.push_back('{1'b0,   1, 1'b0, 1'b0, 2, 1'b1,   0, 0});
        tbl.push_back('{1'b0, 400, 1'b0, 1'b0, 2, 1'b1, 400, 0});
        tbl.push_back('{1'b0,   1, 1'b1, 1'b0, 2, 1'b1, 400, 1});
        tbl.push_back('{1'b0,  10, 1'b0, 1'b0, 2, 1'b1, 410, 1});
        tbl.push_back('{1'b0,  37, 1'b0, 1'b0, 2, 1'b1, 447, 1});
        tbl.push_back('{1'b0,   7, 1'b1, 1'b0, 2, 1'b1, 447, 8});
        tbl.push_back('{1'b0,   1, 1'b1, 1'b0, 0, 1'b0, 447, 9});
        tbl.push_back('{1'b0,  22, 1'b0, 1'b0, 1, 1'b0, 447, 9});
        tbl.push_back('{1'b0,   1, 1'b0, 1'b0, 2, 1'b1, 447, 9});
        tbl.push_back('{1'b1,   2, 1'b0, 1'b0, 0, 1'b0,   0, 0});
        tbl.push_back('{1'b0,   7, 1'b0, 1'b0, 1, 1'b0,   0, 0});
        tbl.push_back('{1'b0,   9, 1'b0, 1'b0, 1, 1'b0,   0, 0});
        tbl.push_back('{1'b0,   1, 1'b1, 1'b0, 0, 1'b0,   0, 0});
        tbl.push_back('{1'b0,  22, 1'b0, 1'b0, 1, 1'b0,   0, 0});
        tbl.push_back('{1'b0,   1, 1'b0, 1'b0, 2, 1'b1,   0, 0});
        tbl.push_back('{1'b0,   5, 1'b0, 1'b0, 2, 1'b1,   5, 0});
        tbl.push_back('{1'b0,   1, 1'b1, 1'b0, 2, 1'b1,   5, 1});
        tbl.push_back('{1'b0,   1, 1'b1, 1'b1, 2, 1'b1,   0, 0});
        tbl.push_back('{1'b0,   3, 1'b0, 1'b0, 2, 1'b1,   3, 0});

        // Reset for 4 cycles.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_exp("reset", 0, 1'b0, 0, 0);

        foreach (tbl[k]) begin
            if (tbl[k].rst_c) begin
                for (int i = 0; i < tbl[k].n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                for (int i = 0; i < tbl[k].n; i++)
                    drive(1'b1, gen_bit() ^ tbl[k].flip, tbl[k].clr, 1'b0);
            end
            check_exp($sformatf("row%0d", k), tbl[k].st, tbl[k].lk, tbl[k].num, tbl[k].err);
        end

        // Saturation of the narrow build, then reset in the middle of RUN.
        clean_bits(251);
        check_exp("pre_sat", 2, 1'b1, 254, 0);
        clean_bits(3);
        check_exp("sat", 2, 1'b1, 257, 0);
        drive(1'b1, gen_bit(), 1'b0, 1'b1);
        check_exp("rst_run", 0, 1'b0, 0, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            burst = (i / 500) % 2;
            v = ($urandom_range(0, 3) != 0);
            f = burst ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 149) == 0);
            r = ($urandom_range(0, 999) == 0);
            b = v ? (gen_bit() ^ f) : 1'($urandom_range(0, 1));
            drive(v, b, c, r);
            check_exp($sformatf("rand%0d", i), m_mode, m_mode == 2, m_num, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
